// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan controller.
// Decode table, blanking values and digit-index helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam int         IDX_W   = $clog2(8);

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Index of the most significant nonzero nibble, 0 when all zero
  function automatic logic [IDX_W-1:0] msd_idx(
    input logic [31:0] v
  );
    msd_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (v[i*4 +: 4] != 4'h0) begin
        msd_idx = IDX_W'(i);
      end
    end
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to 7-segment decoder.
// Output is active-low {g,f,e,d,c,b,a}.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for one nibble
  always_comb begin
    seg_o = SEG_LUT[nib_i];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit multiplexed 7-seg scanner with frame-synced load.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int DIGITS  = 8
) (
  input  logic        clk_i,
  input  logic        nreset_i,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic [7:0]  dp_mask_i,
  input  logic [7:0]  en_mask_i,
  output logic [6:0]  hex_o,
  output logic        dp_o,
  output logic [7:0]  an_o,
  output logic        frame_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(DIGITS - 1);

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             tick;
  logic             wrap;
  logic [31:0]      disp;
  logic [31:0]      disp_nxt;
  logic [31:0]      pend;
  logic             pend_v;
  logic [3:0]       nib;
  logic [6:0]       seg;
  logic             shown;

  // Tick, next index and the value the next digit is drawn from
  always_comb begin
    tick     = (presc == P_LAST);
    wrap     = tick && (idx == I_LAST);
    idx_nxt  = (idx == I_LAST) ? '0 : idx + 1'b1;
    disp_nxt = (wrap && pend_v) ? pend : disp;
    nib      = disp_nxt[{idx_nxt, 2'b00} +: 4];
  end

  // Whether the digit about to be selected is lit
`ifdef SEG7_LZB_EN
  always_comb begin
    shown = en_mask_i[idx_nxt]
         && (idx_nxt <= msd_idx(disp_nxt));
  end
`else
  always_comb begin
    shown = en_mask_i[idx_nxt];
  end
`endif

  hex_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (seg)
  );

  assign data_ready_o = ~pend_v;

  // Prescaler, digit scan, commit and registered pin drive
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      presc   <= '0;
      idx     <= I_LAST;
      disp    <= '0;
      an_o    <= AN_OFF;
      hex_o   <= SEG_OFF;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      frame_o <= wrap;
      if (tick) begin
        idx  <= idx_nxt;
        disp <= disp_nxt;
        if (shown) begin
          an_o  <= ~(8'h01 << idx_nxt);
          hex_o <= seg;
          dp_o  <= ~dp_mask_i[idx_nxt];
        end else begin
          an_o  <= AN_OFF;
          hex_o <= SEG_OFF;
          dp_o  <= 1'b1;
        end
      end
    end
  end

  // Single-entry pending slot, drained at the frame wrap
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (data_valid_i && !pend_v) begin
      pend   <= data_i;
      pend_v <= 1'b1;
    end else if (wrap) begin
      pend_v <= 1'b0;
    end
  end

endmodule
